// File: rtl/hdmi_video_timing_gen_pkg.sv
// Shared constants and types for the HDMI raster timing generator.
// Presets, polarity levels and the delayed-signal bundle.
package hdmi_timing_pkg;

   localparam int CW_DEF = 12;

   localparam bit POL_LOW  = 1'b0;
   localparam bit POL_HIGH = 1'b1;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam bit VGA_HS_POL   = POL_LOW;
   localparam bit VGA_VS_POL   = POL_LOW;

   localparam int HD720_H_ACTIVE = 1280;
   localparam int HD720_H_FP     = 110;
   localparam int HD720_H_SYNC   = 40;
   localparam int HD720_H_BP     = 220;
   localparam int HD720_V_ACTIVE = 720;
   localparam int HD720_V_FP     = 5;
   localparam int HD720_V_SYNC   = 5;
   localparam int HD720_V_BP     = 20;
   localparam bit HD720_HS_POL   = POL_HIGH;
   localparam bit HD720_VS_POL   = POL_HIGH;

   typedef struct packed {
      logic       frame_start;
      logic       line_start;
      logic [1:0] ctrl;
      logic       de;
   } vid_sig_t;

   localparam int VID_SIG_W = $bits(vid_sig_t);

   function automatic int line_total(
      input int act,
      input int fp,
      input int sync,
      input int bp
   );
      return act + fp + sync + bp;
   endfunction

   function automatic logic [1:0] ctrl_enc(
      input logic vs,
      input logic hs,
      input logic vs_pol,
      input logic hs_pol
   );
      return {vs ? vs_pol : ~vs_pol,
              hs ? hs_pol : ~hs_pol};
   endfunction

endpackage

// File: rtl/hdmi_video_timing_gen_if.sv
// Video timing bundle from the raster generator to the
// pixel source (requests) and TMDS encoders (de/ctrl).
interface hdmi_video_timing_gen_if
   import hdmi_timing_pkg::*;
#(
   parameter int CW = CW_DEF
) ();

   logic          de_req;
   logic [CW-1:0] x_req;
   logic [CW-1:0] y_req;
   logic          de;
   logic [1:0]    ctrl;
   logic          line_start;
   logic          frame_start;

   modport master (
      output de_req,
      output x_req,
      output y_req,
      output de,
      output ctrl,
      output line_start,
      output frame_start
   );

   modport slave (
      input de_req,
      input x_req,
      input y_req,
      input de,
      input ctrl,
      input line_start,
      input frame_start
   );

endinterface

// File: rtl/hdmi_sig_delay.sv
// DEPTH x WIDTH shift pipe; async reset and sync flush both
// load every stage with RST_VAL.
module hdmi_sig_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("hdmi_sig_delay: DEPTH must be >= 1");
   end

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= RST_VAL;
         end
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= RST_VAL;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Raster counters, sync/active decode and request registers;
// encoder-side signals trail the requests by PIX_LEAD clocks.
module hdmi_video_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = VGA_HS_POL,
   parameter bit VS_POL   = VGA_VS_POL,
   parameter int PIX_LEAD = 1,
   parameter int CW       = CW_DEF
) (
   input  logic clk,
   input  logic Reset_n,
   input  logic en,
   hdmi_video_timing_gen_if.master vid
);

   localparam int H_TOTAL =
      line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL =
      line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW))
   begin : g_bad_total
      $error("raster total does not fit in CW bits");
   end
   if (PIX_LEAD < 0 || PIX_LEAD > 4) begin : g_bad_lead
      $error("PIX_LEAD must be 0..4");
   end

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   // One extra bit so sync-end bounds equal to 2**CW stay exact
   localparam logic [CW:0] H_ACT_E = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0] HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END  =
      (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] V_ACT_E = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0] VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_END  =
      (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam vid_sig_t IDLE_SIG = '{
      frame_start: 1'b0,
      line_start:  1'b0,
      ctrl:        {~VS_POL, ~HS_POL},
      de:          1'b0
   };

   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;
   logic [CW:0]   hx, vx;
   logic          h_last, v_last;
   logic          act, hs, vs;

   logic          de_req_q, de_req_d;
   logic [CW-1:0] x_req_q, x_req_d;
   logic [CW-1:0] y_req_q, y_req_d;
   vid_sig_t      sig_q, sig_d, sig_o;

   always_comb begin
      h_last = (hcnt_q == H_LAST);
      v_last = (vcnt_q == V_LAST);
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (h_last) begin
         hcnt_d = '0;
         vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      end
      if (!en) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end
   end

   always_comb begin
      hx  = {1'b0, hcnt_q};
      vx  = {1'b0, vcnt_q};
      act = (hx < H_ACT_E) && (vx < V_ACT_E);
      hs  = (hx >= HS_BEG) && (hx < HS_END);
      vs  = (vx >= VS_BEG) && (vx < VS_END);
   end

   always_comb begin
      de_req_d = en & act;
      x_req_d  = de_req_d ? hcnt_q : '0;
      y_req_d  = de_req_d ? vcnt_q : '0;
      sig_d    = IDLE_SIG;
      if (en) begin
         sig_d.de          = act;
         sig_d.ctrl        = ctrl_enc(vs, hs, VS_POL, HS_POL);
         sig_d.line_start  = (hcnt_q == '0);
         sig_d.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         de_req_q <= 1'b0;
         x_req_q  <= '0;
         y_req_q  <= '0;
         sig_q    <= IDLE_SIG;
      end else begin
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         de_req_q <= de_req_d;
         x_req_q  <= x_req_d;
         y_req_q  <= y_req_d;
         sig_q    <= sig_d;
      end
   end

   if (PIX_LEAD == 0) begin : g_nolead
      assign sig_o = sig_q;
   end else begin : g_lead
      hdmi_sig_delay #(
         .DEPTH   (PIX_LEAD),
         .WIDTH   (VID_SIG_W),
         .RST_VAL (IDLE_SIG)
      ) u_dly (
         .clk     (clk),
         .rst_n   (Reset_n),
         .flush_i (~en),
         .d_i     (sig_q),
         .q_o     (sig_o)
      );
   end

   assign vid.de_req      = de_req_q;
   assign vid.x_req       = x_req_q;
   assign vid.y_req       = y_req_q;
   assign vid.de          = sig_o.de;
   assign vid.ctrl        = sig_o.ctrl;
   assign vid.line_start  = sig_o.line_start;
   assign vid.frame_start = sig_o.frame_start;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench: tiny raster (lead 0), VGA defaults (lead 2)
// and an active-high-sync raster (lead 1) with reset pulse.
module tb_hdmi_video_timing_gen;

   int tests = 0;
   int fails = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s = 1'b0, en_s = 1'b1;
   logic rst_d = 1'b0, en_d = 1'b1;
   logic rst_p = 1'b0, en_p = 1'b1;

   hdmi_video_timing_gen_if #(.CW(4))  if_s ();
   hdmi_video_timing_gen_if #(.CW(12)) if_d ();
   hdmi_video_timing_gen_if #(.CW(12)) if_p ();

   hdmi_video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .PIX_LEAD(0), .CW(4)
   ) u_s (
      .clk(clk), .Reset_n(rst_s), .en(en_s), .vid(if_s)
   );

   hdmi_video_timing_gen #(
      .PIX_LEAD(2)
   ) u_d (
      .clk(clk), .Reset_n(rst_d), .en(en_d), .vid(if_d)
   );

   hdmi_video_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(96), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .PIX_LEAD(1), .CW(12)
   ) u_p (
      .clk(clk), .Reset_n(rst_p), .en(en_p), .vid(if_p)
   );

   typedef struct {
      bit act;
      int x;
      int y;
      bit hs;
      bit vs;
      bit ls;
      bit fs;
   } exp_t;

   // Expected raster state for count index n (n<0: idle)
   function automatic exp_t model(
      input int n,
      input int ha, input int hf, input int hw, input int hb,
      input int va, input int vf, input int vw, input int vb
   );
      exp_t e;
      int ht, vt, h, v;
      e = '{default: 0};
      if (n < 0) return e;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      h = n % ht;
      v = (n / ht) % vt;
      e.act = (h < ha) && (v < va);
      e.x = e.act ? h : 0;
      e.y = e.act ? v : 0;
      e.hs = (h >= ha + hf) && (h < ha + hf + hw);
      e.vs = (v >= va + vf) && (v < va + vf + vw);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      return e;
   endfunction

   int kd = 0;

   task automatic test_reset();
      logic [13:0] gs;
      logic [29:0] gd, gp;
      repeat (3) @(negedge clk);
      gs = {if_s.de_req, if_s.x_req, if_s.y_req, if_s.de,
            if_s.ctrl, if_s.line_start, if_s.frame_start};
      tests++;
      if (gs !== 14'h00C) begin
         fails++;
         $display("FAIL reset_small got=%h want=%h", gs, 14'h00C);
      end
      gd = {if_d.de_req, if_d.x_req, if_d.y_req, if_d.de,
            if_d.ctrl, if_d.line_start, if_d.frame_start};
      tests++;
      if (gd !== 30'h0000000C) begin
         fails++;
         $display("FAIL reset_vga got=%h want=%h", gd, 30'hC);
      end
      gp = {if_p.de_req, if_p.x_req, if_p.y_req, if_p.de,
            if_p.ctrl, if_p.line_start, if_p.frame_start};
      tests++;
      if (gp !== 30'h00000000) begin
         fails++;
         $display("FAIL reset_pol got=%h want=%h", gp, 30'h0);
      end
   endtask

   task automatic test_small_raster();
      bit [7:0] de_line, hs_n;
      bit [5:0] vs_n;
      logic [13:0] got, want;
      int h, v, n, last_fs, nfs;
      bit de_e;
      de_line = 8'b1111_0000;
      hs_n    = 8'b1111_1001;
      vs_n    = 6'b11_1101;
      last_fs = 0;
      nfs = 0;
      rst_s = 1'b1;
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         n = k - 1;
         h = n % 8;
         v = (n / 8) % 6;
         de_e = de_line[7-h] && (v < 3);
         want = {de_e, de_e ? 4'(h) : 4'd0,
                 de_e ? 4'(v) : 4'd0, de_e,
                 vs_n[5-v], hs_n[7-h],
                 h == 0, (n % 48) == 0};
         got = {if_s.de_req, if_s.x_req, if_s.y_req, if_s.de,
                if_s.ctrl, if_s.line_start, if_s.frame_start};
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL small_raster k=%0d got=%h want=%h",
                     k, got, want);
         end
         if (if_s.frame_start === 1'b1) begin
            nfs++;
            if (last_fs != 0) begin
               tests++;
               if (k - last_fs != 48) begin
                  fails++;
                  $display("FAIL frame_period got=%0d want=48",
                           k - last_fs);
               end
            end
            last_fs = k;
         end
      end
      tests++;
      if (nfs != 3) begin
         fails++;
         $display("FAIL frame_count got=%0d want=3", nfs);
      end
   endtask

   task automatic test_lead();
      exp_t er, eo;
      logic [24:0] gr, wr;
      logic [4:0]  go, wo;
      int first_req, first_de;
      bit fs_at_de;
      first_req = 0;
      first_de = 0;
      fs_at_de = 1'b0;
      rst_d = 1'b1;
      kd = 0;
      for (int k = 1; k <= 1700; k++) begin
         @(negedge clk);
         kd = k;
         er = model(k - 1, 640, 16, 96, 48, 480, 10, 2, 33);
         eo = model(k - 3, 640, 16, 96, 48, 480, 10, 2, 33);
         wr = {er.act, 12'(er.x), 12'(er.y)};
         wo = {eo.act, ~eo.vs, ~eo.hs, eo.ls, eo.fs};
         gr = {if_d.de_req, if_d.x_req, if_d.y_req};
         go = {if_d.de, if_d.ctrl, if_d.line_start,
               if_d.frame_start};
         tests++;
         if (gr !== wr) begin
            fails++;
            $display("FAIL lead_req k=%0d got=%h want=%h",
                     k, gr, wr);
         end
         tests++;
         if (go !== wo) begin
            fails++;
            $display("FAIL lead_out k=%0d got=%b want=%b",
                     k, go, wo);
         end
         if (first_req == 0 && if_d.de_req === 1'b1)
            first_req = k;
         if (first_de == 0 && if_d.de === 1'b1) begin
            first_de = k;
            fs_at_de = if_d.frame_start;
         end
      end
      tests++;
      if (first_de - first_req != 2) begin
         fails++;
         $display("FAIL lead_gap got=%0d want=2",
                  first_de - first_req);
      end
      tests++;
      if (fs_at_de !== 1'b1) begin
         fails++;
         $display("FAIL lead_fs got=%b want=1", fs_at_de);
      end
   endtask

   task automatic test_en_drop();
      logic [29:0] g, idle;
      idle = 30'h0000000C;
      while (kd < 40101) begin
         @(negedge clk);
         kd++;
      end
      g = {if_d.de_req, if_d.x_req, if_d.y_req, if_d.de,
           if_d.ctrl, if_d.line_start, if_d.frame_start};
      tests++;
      if (g !== {1'b1, 12'd100, 12'd50, 1'b1, 2'b11, 2'b00}) begin
         fails++;
         $display("FAIL en_pre got=%h want=x100,y50,de", g);
      end
      en_d = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         g = {if_d.de_req, if_d.x_req, if_d.y_req, if_d.de,
              if_d.ctrl, if_d.line_start, if_d.frame_start};
         tests++;
         if (g !== idle) begin
            fails++;
            $display("FAIL en_idle i=%0d got=%h want=%h",
                     i, g, idle);
         end
      end
      en_d = 1'b1;
      @(negedge clk);
      g = {if_d.de_req, if_d.x_req, if_d.y_req, if_d.de,
           if_d.ctrl, if_d.line_start, if_d.frame_start};
      tests++;
      if (g !== {1'b1, 12'd0, 12'd0, 1'b0, 2'b11, 2'b00}) begin
         fails++;
         $display("FAIL en_restart1 got=%h want=req x0 y0", g);
      end
      @(negedge clk);
      tests++;
      if (if_d.de !== 1'b0 || if_d.x_req !== 12'd1) begin
         fails++;
         $display("FAIL en_restart2 got de=%b x=%0d want de=0 x=1",
                  if_d.de, if_d.x_req);
      end
      @(negedge clk);
      tests++;
      if (if_d.de !== 1'b1 || if_d.frame_start !== 1'b1 ||
          if_d.x_req !== 12'd2) begin
         fails++;
         $display("FAIL en_restart3 got de=%b fs=%b x=%0d want 1 1 2",
                  if_d.de, if_d.frame_start, if_d.x_req);
      end
   endtask

   task automatic test_reset_pulse();
      exp_t er, eo;
      logic [24:0] gr, wr;
      logic [4:0]  go, wo;
      logic [29:0] g;
      rst_p = 1'b1;
      for (int k = 1; k <= 131; k++) begin
         @(negedge clk);
         er = model(k - 1, 16, 4, 96, 4, 4, 1, 2, 1);
         eo = model(k - 2, 16, 4, 96, 4, 4, 1, 2, 1);
         wr = {er.act, 12'(er.x), 12'(er.y)};
         wo = {eo.act, eo.vs, eo.hs, eo.ls, eo.fs};
         gr = {if_p.de_req, if_p.x_req, if_p.y_req};
         go = {if_p.de, if_p.ctrl, if_p.line_start,
               if_p.frame_start};
         tests++;
         if ({gr, go} !== {wr, wo}) begin
            fails++;
            $display("FAIL pulse_pre k=%0d got=%h want=%h",
                     k, {gr, go}, {wr, wo});
         end
      end
      @(posedge clk);
      #2 rst_p = 1'b0;
      #1;
      g = {if_p.de_req, if_p.x_req, if_p.y_req, if_p.de,
           if_p.ctrl, if_p.line_start, if_p.frame_start};
      tests++;
      if (g !== 30'h0) begin
         fails++;
         $display("FAIL pulse_async got=%h want=0", g);
      end
      @(negedge clk);
      g = {if_p.de_req, if_p.x_req, if_p.y_req, if_p.de,
           if_p.ctrl, if_p.line_start, if_p.frame_start};
      tests++;
      if (g !== 30'h0) begin
         fails++;
         $display("FAIL pulse_hold got=%h want=0", g);
      end
      rst_p = 1'b1;
   endtask

   task automatic test_polarity();
      exp_t er, eo;
      logic [24:0] gr, wr;
      logic [4:0]  go, wo;
      int hs_cnt, vs_cnt, run;
      hs_cnt = 0;
      vs_cnt = 0;
      run = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         er = model(k - 1, 16, 4, 96, 4, 4, 1, 2, 1);
         eo = model(k - 2, 16, 4, 96, 4, 4, 1, 2, 1);
         wr = {er.act, 12'(er.x), 12'(er.y)};
         wo = {eo.act, eo.vs, eo.hs, eo.ls, eo.fs};
         gr = {if_p.de_req, if_p.x_req, if_p.y_req};
         go = {if_p.de, if_p.ctrl, if_p.line_start,
               if_p.frame_start};
         tests++;
         if ({gr, go} !== {wr, wo}) begin
            fails++;
            $display("FAIL pol k=%0d got=%h want=%h",
                     k, {gr, go}, {wr, wo});
         end
         if (k >= 2 && k <= 961) begin
            if (if_p.ctrl[0] === 1'b1) hs_cnt++;
            if (if_p.ctrl[1] === 1'b1) vs_cnt++;
         end
         if (if_p.ctrl[0] === 1'b1) begin
            run++;
         end else if (run > 0) begin
            tests++;
            if (run != 96) begin
               fails++;
               $display("FAIL hs_width got=%0d want=96", run);
            end
            run = 0;
         end
      end
      tests++;
      if (hs_cnt != 768) begin
         fails++;
         $display("FAIL hs_total got=%0d want=768", hs_cnt);
      end
      tests++;
      if (vs_cnt != 240) begin
         fails++;
         $display("FAIL vs_total got=%0d want=240", vs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_small_raster();
      test_lead();
      test_en_drop();
      test_reset_pulse();
      test_polarity();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
